// File: rtl/sram_responder.sv
// sram_responder
//   On-chip stand-in for an external asynchronous SRAM. It sits on the phy
//   side of the SRAM controller interface for loopback builds and acts as the
//   target when verifying the controller. Writes are two-phase: the command
//   captures the address and the data arrives one clock later. Reads return
//   data after a fixed latency through a valid/data shift register.
//
//   Optional feature: define SRAM_RESPONDER_BOUNDS_EN to flag and drop
//   accesses at or above `depth`. Without it, addresses wrap modulo `depth`
//   and `err` is tied low.
//
// Parameters
//   aw      address width of sram_addr
//   dw      data width
//   depth   implemented words (power of two, <= 2**aw)
//   latency read latency in clocks (1..4)
//
// Ports
//   clk            clock, rising edge
//   rst_n          asynchronous active-low reset
//   sram_addr      word address
//   sram_ce_n      chip enable, active low (high = idle)
//   sram_oe_n      output enable, active low
//   sram_we_n      write enable, active low, overrides sram_oe_n
//   sram_dat_wr    write data, sampled one clock after the write command
//   sram_dat_rd    read data, holds its last value between responses
//   sram_dat_rd_oe high for the one cycle a read response is presented
//   wr_count       committed writes, saturating
//   rd_count       completed reads, saturating
//   err            sticky out-of-range flag (bounds build only)
module sram_responder #(
  parameter int aw      = 19,
  parameter int dw      = 8,
  parameter int depth   = 1024,
  parameter int latency = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [aw-1:0] sram_addr,
  input  logic          sram_ce_n,
  input  logic          sram_oe_n,
  input  logic          sram_we_n,
  input  logic [dw-1:0] sram_dat_wr,
  output logic [dw-1:0] sram_dat_rd,
  output logic          sram_dat_rd_oe,
  output logic [15:0]   wr_count,
  output logic [15:0]   rd_count,
  output logic          err
);

  localparam int iw = $clog2(depth);

  logic          wr_cmd;
  logic          rd_cmd;
  logic          oob;
  logic          wr_take;
  logic          wr_pend;
  logic [iw-1:0] cmd_idx;
  logic [iw-1:0] wr_idx;
  logic [dw-1:0] rd_data;
  logic          out_v;
  logic [dw-1:0] out_d;

  logic [dw-1:0] mem [depth];

  assign wr_cmd  = !sram_ce_n && !sram_we_n;
  assign rd_cmd  = !sram_ce_n &&  sram_we_n && !sram_oe_n;
  assign cmd_idx = sram_addr[iw-1:0];

`ifdef SRAM_RESPONDER_BOUNDS_EN
  localparam logic [aw:0] depth_lim = (aw+1)'(depth);

  logic err_q;

  assign oob = ({1'b0, sram_addr} >= depth_lim);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if ((wr_cmd || rd_cmd) && oob) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  // Upper address bits are ignored: the array aliases every `depth` words.
  logic unused_addr_hi;
  assign unused_addr_hi = ^sram_addr[aw-1:iw];
  assign oob = 1'b0;
  assign err = 1'b0;
`endif

  // An out-of-range write never becomes pending, so it is neither stored
  // nor counted.
  assign wr_take = wr_cmd && !oob;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_pend <= 1'b0;
      wr_idx  <= '0;
    end else begin
      wr_pend <= wr_take;
      if (wr_take) begin
        wr_idx <= cmd_idx;
      end
    end
  end

  // Array contents survive reset; wr_pend is cleared asynchronously so a
  // write interrupted by reset never lands.
  always_ff @(posedge clk) begin
    if (wr_pend) begin
      mem[wr_idx] <= sram_dat_wr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_count <= '0;
    end else if (wr_pend && (wr_count != 16'hFFFF)) begin
      wr_count <= wr_count + 16'd1;
    end
  end

  // A read hitting the write that commits on this same edge takes the data
  // straight from the bus, since the array still holds the old word.
  always_comb begin
    rd_data = mem[cmd_idx];
    if (wr_pend && (wr_idx == cmd_idx)) begin
      rd_data = sram_dat_wr;
    end
    if (oob) begin
      rd_data = '0;
    end
  end

  // The output register is the last pipeline stage, so latency-1 extra
  // stages sit in front of it.
  generate
    if (latency == 1) begin : g_direct
      assign out_v = rd_cmd;
      assign out_d = rd_data;
    end else begin : g_pipe
      logic [latency-2:0] v_sr;
      logic [dw-1:0]      d_sr [latency-1];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_sr <= '0;
        end else begin
          v_sr[0] <= rd_cmd;
          for (int i = 1; i < latency - 1; i++) begin
            v_sr[i] <= v_sr[i-1];
          end
        end
      end

      always_ff @(posedge clk) begin
        d_sr[0] <= rd_data;
        for (int i = 1; i < latency - 1; i++) begin
          d_sr[i] <= d_sr[i-1];
        end
      end

      assign out_v = v_sr[latency-2];
      assign out_d = d_sr[latency-2];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sram_dat_rd    <= '0;
      sram_dat_rd_oe <= 1'b0;
      rd_count       <= '0;
    end else begin
      sram_dat_rd_oe <= out_v;
      if (out_v) begin
        sram_dat_rd <= out_d;
        if (rd_count != 16'hFFFF) begin
          rd_count <= rd_count + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder
//   Directed bench for sram_responder. Three instances with read latency 1, 2
//   and 4 share one command bus, so every step exercises all latencies. The
//   bounds step follows SRAM_RESPONDER_BOUNDS_EN when it is defined.
module tb_sram_responder;

  logic        clk;
  logic        rst_n;
  logic [18:0] sram_addr;
  logic        sram_ce_n;
  logic        sram_oe_n;
  logic        sram_we_n;
  logic [7:0]  sram_dat_wr;

  logic [7:0]  rd_v  [3];
  logic        oe_v  [3];
  logic [15:0] wc_v  [3];
  logic [15:0] rc_v  [3];
  logic        err_v [3];

  int          lat [3] = '{1, 2, 4};
  logic [7:0]  exp_d [4];
  int          n_chk  = 0;
  int          n_pass = 0;
  int          wc_exp = 0;
  int          rc_exp = 0;

  sram_responder #(.aw(19), .dw(8), .depth(1024), .latency(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .sram_addr(sram_addr), .sram_ce_n(sram_ce_n),
    .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n), .sram_dat_wr(sram_dat_wr),
    .sram_dat_rd(rd_v[0]), .sram_dat_rd_oe(oe_v[0]), .wr_count(wc_v[0]),
    .rd_count(rc_v[0]), .err(err_v[0]));

  sram_responder #(.aw(19), .dw(8), .depth(1024), .latency(2)) u_l2 (
    .clk(clk), .rst_n(rst_n), .sram_addr(sram_addr), .sram_ce_n(sram_ce_n),
    .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n), .sram_dat_wr(sram_dat_wr),
    .sram_dat_rd(rd_v[1]), .sram_dat_rd_oe(oe_v[1]), .wr_count(wc_v[1]),
    .rd_count(rc_v[1]), .err(err_v[1]));

  sram_responder #(.aw(19), .dw(8), .depth(1024), .latency(4)) u_l4 (
    .clk(clk), .rst_n(rst_n), .sram_addr(sram_addr), .sram_ce_n(sram_ce_n),
    .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n), .sram_dat_wr(sram_dat_wr),
    .sram_dat_rd(rd_v[2]), .sram_dat_rd_oe(oe_v[2]), .wr_count(wc_v[2]),
    .rd_count(rc_v[2]), .err(err_v[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic idle();
    sram_ce_n = 1'b1;
    sram_we_n = 1'b1;
    sram_oe_n = 1'b1;
  endtask

  task automatic check_counts(input string tag);
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("%s wr_count L%0d", tag, lat[j]), 32'(wc_v[j]), 32'(wc_exp));
      chk($sformatf("%s rd_count L%0d", tag, lat[j]), 32'(rc_v[j]), 32'(rc_exp));
    end
  endtask

  task automatic check_zero(input string tag);
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("%s rd L%0d", tag, lat[j]), 32'(rd_v[j]), 32'h0);
      chk($sformatf("%s oe L%0d", tag, lat[j]), 32'(oe_v[j]), 32'h0);
      chk($sformatf("%s wc L%0d", tag, lat[j]), 32'(wc_v[j]), 32'h0);
      chk($sformatf("%s rc L%0d", tag, lat[j]), 32'(rc_v[j]), 32'h0);
      chk($sformatf("%s err L%0d", tag, lat[j]), 32'(err_v[j]), 32'h0);
    end
  endtask

  // Back-to-back writes of exp_d[0..n-1] to base..base+n-1; each data word
  // is driven in the cycle after its command.
  task automatic wr_burst(input logic [18:0] base, input int n, input int counted);
    for (int t = 0; t <= n; t++) begin
      if (t < n) begin
        sram_ce_n = 1'b0;
        sram_we_n = 1'b0;
        sram_oe_n = 1'b1;
        sram_addr = 19'(base + 19'(t));
      end else begin
        idle();
      end
      if (t > 0) sram_dat_wr = exp_d[t-1];
      tick();
    end
    wc_exp += counted;
    check_counts("wr_burst");
  endtask

  // Back-to-back reads of base..base+n-1, expecting exp_d[0..n-1]. Checks
  // every instance every cycle: response k appears after edge k+lat-1.
  task automatic rd_burst(input logic [18:0] base, input int n, input logic [7:0] dv);
    sram_dat_wr = dv;
    for (int t = 0; t < n + 4; t++) begin
      if (t < n) begin
        sram_ce_n = 1'b0;
        sram_we_n = 1'b1;
        sram_oe_n = 1'b0;
        sram_addr = 19'(base + 19'(t));
      end else begin
        idle();
      end
      tick();
      for (int j = 0; j < 3; j++) begin
        int   k;
        logic e;
        k = t - (lat[j] - 1);
        e = (k >= 0) && (k < n);
        chk($sformatf("rd_oe L%0d a%0d t%0d", lat[j], base, t), 32'(oe_v[j]), 32'(e));
        if (e) chk($sformatf("rd_data L%0d a%0d t%0d", lat[j], base, t), 32'(rd_v[j]), 32'(exp_d[k]));
      end
    end
    rc_exp += n;
    check_counts("rd_burst");
  endtask

  initial begin
    rst_n       = 1'b0;
    sram_addr   = '0;
    sram_dat_wr = '0;
    idle();
    tick();
    tick();
    check_zero("reset");
    rst_n = 1'b1;
    tick();

    // single write then read
    exp_d[0] = 8'hA5;
    wr_burst(19'd3, 1, 1);
    rd_burst(19'd3, 1, 8'h00);

    // back-to-back writes and reads
    exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33;
    wr_burst(19'd0, 3, 3);
    rd_burst(19'd0, 3, 8'h00);

    // forwarding: stale 0x00 at address 7, then write 0x5C and read it in
    // the data cycle
    exp_d[0] = 8'h00;
    wr_burst(19'd7, 1, 1);
    sram_ce_n = 1'b0;
    sram_we_n = 1'b0;
    sram_oe_n = 1'b1;
    sram_addr = 19'd7;
    tick();
    wc_exp += 1;
    exp_d[0] = 8'h5C;
    rd_burst(19'd7, 1, 8'h5C);
    rd_burst(19'd7, 1, 8'h00);

    // read command with oe_n high, then idle: nothing happens, bus holds
    for (int t = 0; t < 4; t++) begin
      if (t < 2) begin
        sram_ce_n = 1'b0;
        sram_we_n = 1'b1;
        sram_oe_n = 1'b1;
        sram_addr = 19'd7;
      end else begin
        idle();
      end
      tick();
      for (int j = 0; j < 3; j++) begin
        chk($sformatf("hold oe L%0d t%0d", lat[j], t), 32'(oe_v[j]), 32'h0);
        chk($sformatf("hold rd L%0d t%0d", lat[j], t), 32'(rd_v[j]), 32'h5C);
      end
    end
    check_counts("hold");

    // reset between write command and its data cycle
    sram_ce_n = 1'b0;
    sram_we_n = 1'b0;
    sram_oe_n = 1'b1;
    sram_addr = 19'd3;
    tick();
    rst_n = 1'b0;
    sram_dat_wr = 8'hEE;
    idle();
    #1;
    check_zero("rst_wr");
    tick();
    check_zero("rst_wr_hold");
    rst_n = 1'b1;
    wc_exp = 0;
    rc_exp = 0;
    tick();
    exp_d[0] = 8'hA5;
    rd_burst(19'd3, 1, 8'h00);

    // reset during an in-flight read
    sram_ce_n = 1'b0;
    sram_we_n = 1'b1;
    sram_oe_n = 1'b0;
    sram_addr = 19'd0;
    tick();
    rst_n = 1'b0;
    idle();
    #1;
    check_zero("rst_rd");
    tick();
    rst_n = 1'b1;
    rc_exp = 0;
    wc_exp = 0;
    for (int t = 0; t < 5; t++) begin
      tick();
      for (int j = 0; j < 3; j++)
        chk($sformatf("rst_rd no_resp L%0d t%0d", lat[j], t), 32'(oe_v[j]), 32'h0);
    end
    check_counts("rst_rd");

    // write to address 1024 (one past the array)
    exp_d[0] = 8'h99;
`ifdef SRAM_RESPONDER_BOUNDS_EN
    wr_burst(19'd1024, 1, 0);
    for (int j = 0; j < 3; j++)
      chk($sformatf("oob err L%0d", lat[j]), 32'(err_v[j]), 32'h1);
    exp_d[0] = 8'h11;
    rd_burst(19'd0, 1, 8'h00);
    exp_d[0] = 8'h00;
    rd_burst(19'd1024, 1, 8'h00);
    for (int j = 0; j < 3; j++)
      chk($sformatf("oob err sticky L%0d", lat[j]), 32'(err_v[j]), 32'h1);
`else
    wr_burst(19'd1024, 1, 1);
    for (int j = 0; j < 3; j++)
      chk($sformatf("alias err L%0d", lat[j]), 32'(err_v[j]), 32'h0);
    exp_d[0] = 8'h99;
    rd_burst(19'd0, 1, 8'h00);
    rd_burst(19'd1024, 1, 8'h00);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
